// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
package sar_pkg;

   localparam int SAR_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRIAL = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } sar_state_t;

endpackage : sar_pkg

// File: rtl/sar_search.sv
// Binary-search controller closing the loop around an external magnitude comparator:
// one trial per clock, bitwise set/clear only, early exit on equality.
module sar_search
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       a_greater,
   input  logic                       a_equal,
   input  logic                       a_less,
   output logic [WIDTH-1:0]           guess,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [WIDTH-1:0]           result,
   output logic [$clog2(WIDTH+1)-1:0] iters
);

   localparam int IW = $clog2(WIDTH+1);
   localparam logic [WIDTH-1:0] MSB_BIT  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB_BIT  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]    ITER_ONE = {{(IW-1){1'b0}}, 1'b1};

   sar_state_t       state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    iters_q, iters_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [2:0]       cmp_s;
   logic             cmp_valid_s;
   logic [WIDTH-1:0] trial_guess_s;

   // Comparator sanity and the guess after applying this trial's keep/clear decision.
   always_comb begin
      cmp_s         = {a_greater, a_equal, a_less};
      cmp_valid_s   = (cmp_s == 3'b100) || (cmp_s == 3'b010) || (cmp_s == 3'b001);
      if (a_less) begin
         trial_guess_s = guess_q & ~mask_q;
      end else begin
         trial_guess_s = guess_q;
      end
   end

   // Next-state and datapath update for the search FSM.
   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      mask_d   = mask_q;
      result_d = result_q;
      iters_d  = iters_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = TRIAL;
               guess_d = MSB_BIT;
               mask_d  = MSB_BIT;
               iters_d = {IW{1'b0}};
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         TRIAL: begin
            iters_d = iters_q + ITER_ONE;
            if (!cmp_valid_s) begin
               state_d = ERR;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else if (a_equal) begin
               state_d  = DONE;
               result_d = guess_q;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end else if (mask_q == LSB_BIT) begin
               // Last bit resolved: the cleared/kept guess is the answer.
               state_d  = DONE;
               guess_d  = trial_guess_s;
               result_d = trial_guess_s;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end else begin
               mask_d  = mask_q >> 1;
               guess_d = trial_guess_s | (mask_q >> 1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= {WIDTH{1'b0}};
         mask_q   <= {WIDTH{1'b0}};
         result_q <= {WIDTH{1'b0}};
         iters_q  <= {IW{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         mask_q   <= mask_d;
         result_q <= result_d;
         iters_q  <= iters_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
   assign iters  = iters_q;

endmodule : sar_search
